// File: rtl/trace_buffer.sv
// Instruction trace capture: circular buffer with PC/forced trigger and post-trigger window.
// Define TRACE_TIMESTAMP_EN to store a free-running cycle stamp with each entry.
module trace_buffer #(
   parameter int DEPTH     = 16,
   parameter int PC_W      = 16,
   parameter int IR_W      = 8,
   parameter int CYC_W     = 32,
   parameter int POST_TRIG = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch,
   input  logic [PC_W-1:0]          pc,
   input  logic [IR_W-1:0]          ir,
   input  logic [3:0]               flags,
   input  logic                     arm,
   input  logic [PC_W-1:0]          trig_pc,
   input  logic                     force_trig,
   output logic                     busy,
   output logic                     triggered,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     wrapped,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [CYC_W-1:0]         rd_cycle,
   output logic [PC_W-1:0]          rd_pc,
   output logic [IR_W-1:0]          rd_ir,
   output logic [3:0]               rd_flags
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PRE  = 2'd1;
   localparam logic [1:0] POST = 2'd2;
   localparam logic [1:0] READ = 2'd3;

   localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE  = (AW+1)'(1);
   localparam logic [AW:0]   PT   = (AW+1)'(POST_TRIG);
   localparam logic [AW-1:0] PONE = AW'(1);

   logic [1:0]      state;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     post_left;
   logic            wr_en;
   logic            hit;

   logic [PC_W-1:0] mem_pc [DEPTH];
   logic [IR_W-1:0] mem_ir [DEPTH];
   logic [3:0]      mem_fl [DEPTH];

   assign hit      = (state == PRE) &&
                     (force_trig || (fetch && pc == trig_pc));
   assign wr_en    = fetch && (state == PRE || state == POST);
   // Oldest entry sits count slots behind the write pointer.
   assign rd_ptr   = wr_ptr - count[AW-1:0];
   assign busy     = (state == PRE) || (state == POST);
   assign done     = (state == READ);
   assign rd_valid = done && (count != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         count     <= '0;
         post_left <= '0;
         wrapped   <= 1'b0;
         triggered <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (arm) begin
               state     <= PRE;
               count     <= '0;
               wr_ptr    <= '0;
               wrapped   <= 1'b0;
               triggered <= 1'b0;
            end
            PRE: if (hit) begin
               triggered <= 1'b1;
               post_left <= PT;
               state     <= (POST_TRIG == 0) ? READ : POST;
            end
            POST: if (fetch) begin
               post_left <= post_left - ONE;
               if (post_left == ONE) state <= READ;
            end
            READ: begin
               if (count == '0) begin
                  state <= IDLE;
               end else if (rd_ready) begin
                  count <= count - ONE;
                  if (count == ONE) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (wr_en) begin
            wr_ptr <= wr_ptr + PONE;
            if (count == FULL) wrapped <= 1'b1;
            else               count   <= count + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_pc[wr_ptr] <= pc;
         mem_ir[wr_ptr] <= ir;
         mem_fl[wr_ptr] <= flags;
      end
   end

   assign rd_pc    = rd_valid ? mem_pc[rd_ptr] : '0;
   assign rd_ir    = rd_valid ? mem_ir[rd_ptr] : '0;
   assign rd_flags = rd_valid ? mem_fl[rd_ptr] : '0;

`ifdef TRACE_TIMESTAMP_EN
   logic [CYC_W-1:0] cyc;
   logic [CYC_W-1:0] mem_cyc [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cyc <= '0;
      else      cyc <= cyc + CYC_W'(1);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_cyc[wr_ptr] <= cyc;
   end

   assign rd_cycle = rd_valid ? mem_cyc[rd_ptr] : '0;
`else
   assign rd_cycle = '0;
`endif

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: three instances with POST_TRIG 3, 0 and 2
// share the stimulus; each scenario checks the instance it targets.
module tb_trace_buffer;

   logic        clk;
   logic        rst;
   logic        fetch;
   logic [15:0] pc;
   logic [7:0]  ir;
   logic [3:0]  flags;
   logic        arm;
   logic [15:0] trig_pc;
   logic        force_trig;
   logic        rd_ready;

   logic [2:0]  busy, trg, done, wrp, vld;
   logic [4:0]  cnt [3];
   logic [31:0] cyc [3];
   logic [15:0] rpc [3];
   logic [7:0]  rir [3];
   logic [3:0]  rfl [3];

   int errs;
   int checks;
   logic [15:0] exp_q[$];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int PT = (g == 0) ? 3 : ((g == 1) ? 0 : 2);
      trace_buffer #(
         .DEPTH(16), .PC_W(16), .IR_W(8), .CYC_W(32), .POST_TRIG(PT)
      ) u_dut (
         .clk(clk), .rst(rst), .fetch(fetch), .pc(pc), .ir(ir),
         .flags(flags), .arm(arm), .trig_pc(trig_pc),
         .force_trig(force_trig), .busy(busy[g]), .triggered(trg[g]),
         .done(done[g]), .count(cnt[g]), .wrapped(wrp[g]),
         .rd_valid(vld[g]), .rd_ready(rd_ready), .rd_cycle(cyc[g]),
         .rd_pc(rpc[g]), .rd_ir(rir[g]), .rd_flags(rfl[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      tick();
      rst = 1'b1;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_fetch(input logic [15:0] a);
      fetch = 1'b1;
      pc    = a;
      ir    = a[7:0] ^ 8'h5a;
      flags = a[3:0];
      tick();
      fetch = 1'b0;
   endtask

   task automatic drain(input int k);
      logic [15:0] e;
      for (int i = 0; i < exp_q.size(); i++) begin
         e = exp_q[i];
         rd_ready = 1'b1;
         check("rd_valid", vld[k], 1'b1);
         check("rd_pc", rpc[k], e);
         check("rd_ir", rir[k], e[7:0] ^ 8'h5a);
         check("rd_flags", rfl[k], e[3:0]);
         tick();
      end
      rd_ready = 1'b0;
      check("idle_after_drain", {busy[k], done[k], vld[k]}, 3'b000);
   endtask

   initial begin
      logic [31:0] stamp [4];
      errs = 0;
      checks = 0;
      rst = 1'b1; fetch = 1'b0; pc = '0; ir = '0; flags = '0;
      arm = 1'b0; trig_pc = '0; force_trig = 1'b0; rd_ready = 1'b0;
      tick();

      // reset state
      rst = 1'b0;
      #2;
      check("rst_flags", {busy[0], trg[0], done[0], wrp[0], vld[0]}, 5'b0);
      check("rst_count", cnt[0], 5'd0);
      check("rst_data", {cyc[0], rpc[0], rir[0], rfl[0]}, 60'd0);
      tick();
      rst = 1'b1;

      // basic capture, POST_TRIG=3
      trig_pc = 16'h0150;
      do_arm();
      check("arm_busy", busy[0], 1'b1);
      for (int i = 0; i < 6; i++) do_fetch(16'h0100 + 16'(i));
      check("pre_trig", trg[0], 1'b0);
      do_fetch(16'h0150);
      check("trig_set", {trg[0], busy[0]}, 2'b11);
      for (int i = 1; i < 4; i++) do_fetch(16'h0150 + 16'(i));
      check("basic_done", {done[0], vld[0], busy[0]}, 3'b110);
      check("basic_count", cnt[0], 5'd10);
      check("basic_wrap", wrp[0], 1'b0);
      do_fetch(16'h0154);
      check("basic_drop", cnt[0], 5'd10);
      exp_q = {16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104,
               16'h0105, 16'h0150, 16'h0151, 16'h0152, 16'h0153};
      drain(0);
      check("basic_trg_hold", trg[0], 1'b1);

      // wrap, POST_TRIG=0
      do_reset();
      trig_pc = 16'h0013;
      do_arm();
      for (int i = 0; i < 20; i++) do_fetch(16'(i));
      check("wrap_state", {done[1], vld[1], trg[1]}, 3'b111);
      check("wrap_flag", wrp[1], 1'b1);
      check("wrap_count", cnt[1], 5'd16);
      exp_q.delete();
      for (int i = 4; i < 20; i++) exp_q.push_back(16'(i));
      drain(1);
      check("wrap_hold", wrp[1], 1'b1);

      // forced trigger with empty buffer, POST_TRIG=0
      do_reset();
      trig_pc = 16'hffff;
      do_arm();
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      check("force_empty", {done[1], vld[1], trg[1]}, 3'b101);
      check("force_empty_cnt", cnt[1], 5'd0);
      tick();
      check("force_empty_idle", {done[1], busy[1]}, 2'b00);

      // forced trigger, POST_TRIG=2, then backpressure
      do_reset();
      do_arm();
      for (int i = 0; i < 5; i++) do_fetch(16'h0200 + 16'(i));
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      check("force_trg", {trg[2], busy[2]}, 2'b11);
      check("force_cnt5", cnt[2], 5'd5);
      do_fetch(16'h0205);
      do_fetch(16'h0206);
      check("force_done", done[2], 1'b1);
      check("force_cnt7", cnt[2], 5'd7);
      do_fetch(16'h0207);
      check("force_drop", cnt[2], 5'd7);
      rd_ready = 1'b1;
      check("bp_pc0", rpc[2], 16'h0200);
      tick();
      rd_ready = 1'b0;
      check("bp_cnt6", cnt[2], 5'd6);
      check("bp_pc1", rpc[2], 16'h0201);
      tick();
      check("bp_hold_pc", rpc[2], 16'h0201);
      check("bp_hold_cnt", cnt[2], 5'd6);
      tick();
      check("bp_hold_pc2", rpc[2], 16'h0201);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      check("bp_cnt5", cnt[2], 5'd5);
      exp_q = {16'h0202, 16'h0203, 16'h0204, 16'h0205, 16'h0206};
      drain(2);

      // timestamps: fetch edges see cycle 10, 14, 15, 16
      do_reset();
      trig_pc = 16'h0300;
      repeat (8) tick();
      do_arm();
      tick();
      do_fetch(16'h0300);
      repeat (3) tick();
      do_fetch(16'h0301);
      do_fetch(16'h0302);
      do_fetch(16'h0303);
      check("ts_done", {done[0], cnt[0]}, {1'b1, 5'd4});
`ifdef TRACE_TIMESTAMP_EN
      stamp = '{32'd10, 32'd14, 32'd15, 32'd16};
`else
      stamp = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("ts_pc", rpc[0], 16'h0300 + 16'(i));
         check("ts_cycle", cyc[0], stamp[i]);
         tick();
      end
      rd_ready = 1'b0;

      // asynchronous reset in POST
      do_reset();
      trig_pc = 16'h0400;
      do_arm();
      do_fetch(16'h0400);
      do_fetch(16'h0401);
      check("mid_post", {busy[0], trg[0], cnt[0]}, {2'b11, 5'd2});
      #2;
      rst = 1'b0;
      #1;
      check("async_rst", {busy[0], trg[0], done[0], wrp[0], vld[0]}, 5'b0);
      check("async_cnt", cnt[0], 5'd0);
      tick();
      rst = 1'b1;
      check("post_rst_idle", {busy[0], done[0]}, 2'b00);
      do_arm();
      for (int i = 0; i < 4; i++) do_fetch(16'h0400 + 16'(i));
      check("rearm_cnt", {done[0], cnt[0]}, {1'b1, 5'd4});
      exp_q = {16'h0400, 16'h0401, 16'h0402, 16'h0403};
      drain(0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/trace_buffer.md
# trace_buffer

Synthesizable on-chip instruction trace capture for the GameBoy datapath: records one entry {cycle stamp, PC, IR, ZNHC flags} per instruction fetch into a circular buffer, with a PC-match or forced trigger and a programmable post-trigger window. It sits beside `datapath`, tapping its fetch strobe, PC, IR and F register. It replaces simulation-only `$monitor` tracing with hardware that is read out through a valid/ready stream, oldest entry first.

## Interface
Parameters:
- `DEPTH`, 16: entry count; power of two, ≥ 4.
- `PC_W`, 16: PC width.
- `IR_W`, 8: opcode width.
- `CYC_W`, 32: cycle-stamp width.
- `POST_TRIG`, 8: entries captured after the trigger entry; 0 ≤ POST_TRIG ≤ DEPTH-1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `fetch` in 1: one-cycle strobe, IR loaded this cycle.
- `pc` in PC_W: PC of the fetched instruction.
- `ir` in IR_W: fetched opcode.
- `flags` in 4: {Z,N,H,C}, i.e. F[7:4].
- `arm` in 1: start capture. Honoured only in IDLE.
- `trig_pc` in PC_W: trigger address.
- `force_trig` in 1: immediate trigger while in PRE.
- `busy` out 1: state is PRE or POST.
- `triggered` out 1: trigger has occurred since the last arm.
- `done` out 1: state is READ.
- `count` out $clog2(DEPTH)+1: valid entries remaining.
- `wrapped` out 1: pre-trigger data overwrote older entries.
- `rd_valid` out 1: an entry is presented.
- `rd_ready` in 1: consumer accepts the entry.
- `rd_cycle` out CYC_W, `rd_pc` out PC_W, `rd_ir` out IR_W, `rd_flags` out 4: fields of the presented entry.

## Operation
- States: IDLE, PRE, POST, READ.
- Cycle counter: free-running from reset, +1 per clk, wraps modulo 2^CYC_W. The stamp is the counter value on the fetch edge.
- IDLE → PRE on `arm`. Clears `count`, `wr_ptr`, `wrapped` and `triggered`.
- PRE, on `fetch`:
  - Writes the entry at `wr_ptr`, then wr_ptr+1 modulo DEPTH.
  - `count` increments and saturates at DEPTH. A write at count==DEPTH sets `wrapped`.
- Trigger in PRE: `fetch && pc==trig_pc`, or `force_trig`.
  - The trigger sets `triggered` and loads `post_left` = POST_TRIG.
  - A PC-match trigger fetch is itself written as the trigger entry.
  - A force without a fetch writes nothing.
  - Force and a matching fetch in the same cycle form one trigger plus one entry.
  - After the trigger: if POST_TRIG=0, go to READ; otherwise go to POST.
- POST: each `fetch` writes an entry (same rules as PRE) and decrements `post_left`. The write that takes `post_left` to 0 moves the state to READ.
- READ:
  - `rd_valid`=1 while count>0. Read pointer starts at wr_ptr−count (mod DEPTH), the oldest entry.
  - `rd_valid && rd_ready`: read pointer +1, `count`−1.
  - The handshake that takes count to 0 moves the state to IDLE. `triggered` and `wrapped` hold until the next arm.
  - A forced trigger with count==0 enters READ and drops straight to IDLE the next cycle with `rd_valid`=0.
- Input gating:
  - `fetch` is ignored in IDLE and READ.
  - `arm` is ignored outside IDLE.
  - `force_trig` is ignored outside PRE.
- Read data comes combinationally from the array at the read pointer and is stable while `rd_valid && !rd_ready`.

## Timing
- Reset (`rst`=0): state IDLE.
  - Outputs `busy`, `triggered`, `done`, `count`, `wrapped`, `rd_valid` = 0.
  - `rd_*` data outputs = 0 (array contents are don't-care).
  - Cycle counter = 0.
  - Reset takes effect immediately and aborts capture or readout.
- `arm` at edge N: `busy`=1 after N. A `fetch` at edge N+1 is the first captured.
- Trigger at edge N: state updates after N. With POST_TRIG=0, `rd_valid`=1 in the cycle after N.
- Final post-trigger write at edge N: `done`=1 and `rd_valid`=1 after N. A `fetch` at N+1 is dropped.
- Throughput: one entry per cycle when `rd_ready` is held high. Capture accepts `fetch` on every cycle.

## Configuration
- `TRACE_TIMESTAMP_EN` defined: cycle counter instantiated. Entry width is CYC_W+PC_W+IR_W+4 and `rd_cycle` carries the stamp.
- Not defined: no counter and no cycle field in the array. `rd_cycle` is tied to 0. All other behaviour is identical.

## Test plan
- Basic capture: DEPTH=16, POST_TRIG=3, trig_pc=0x0150. Arm, then fetch PCs 0x0100..0x0105, 0x0150, 0x0151..0x0153. Required: READ with count=10 and wrapped=0. Stream order is 0x0100…0x0153, and the 7th entry has pc=0x0150.
- Wrap: DEPTH=16, POST_TRIG=0. Fetch 20 PCs 0x0000..0x0013 with trigger on 0x0013. Required: wrapped=1, count=16, and readout 0x0004..0x0013 in order.
- Force trigger: force_trig pulsed with no fetch after 5 fetches, POST_TRIG=2, then 2 fetches. Required: count=7, and a 3rd post-trigger fetch is not captured.
- Backpressure: in READ, rd_ready toggled 1,0,0,1. Required: rd_pc holds while rd_ready=0, count decrements only on handshakes, and IDLE follows the last handshake.
- Timestamps with `TRACE_TIMESTAMP_EN`: fetches at cycles 10, 14, 15. Required: rd_cycle reads back 10, 14, 15. Without the macro: rd_cycle=0.
- Reset mid-POST: `rst` pulled to 0 asynchronously. Required: all outputs 0 immediately, state IDLE after release, and a subsequent arm works normally.
